// File: rtl/ecc_err_logger.sv
// ecc_err_logger: buffers ECC SEC/DED events and drains each record as two APB writes (ADDR, STAT)
module ecc_err_logger #(
    parameter int ADDR_WIDTH = 12,
    parameter int PARITY_BITS = 6,
    parameter int REG_ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH = 8,
    parameter logic [REG_ADDR_WIDTH-1:0] ADDR_REG_OFS = 10'h010,
    parameter logic [REG_ADDR_WIDTH-1:0] STAT_REG_OFS = 10'h014
) (
    input  logic                      ecc_err_logger_clk,
    input  logic                      ecc_err_logger_rst,
    input  logic                      err_valid_i,
    input  logic [1:0]                err_type_i,
    input  logic [ADDR_WIDTH-1:0]     err_addr_i,
    input  logic [PARITY_BITS:0]      syndrome_i,
    input  logic                      irq_en_i,
    input  logic                      irq_clr_i,
    output logic                      o_psel,
    output logic                      o_penable,
    output logic [REG_ADDR_WIDTH-1:0] o_paddr,
    output logic                      o_pwrite,
    output logic [31:0]               o_pwdata,
    output logic [3:0]                o_pstrb,
    input  logic                      i_pready,
    output logic [CNT_WIDTH-1:0]      sec_cnt_o,
    output logic [CNT_WIDTH-1:0]      ded_cnt_o,
    output logic                      irq_o
);
    localparam int SW = PARITY_BITS + 1;
    localparam int RW = 2 + ADDR_WIDTH + SW;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, A_SETUP, A_ACCESS, S_SETUP, S_ACCESS} state_t;

    state_t         state;
    logic [RW-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr, rd_next;
    logic [CW-1:0]  count, count_next;
    logic           ovf, accept, full, pop, push, ovf_set, irq_set;
    logic [1:0]     cur_type;
    logic [RW-1:0]  rec_in, nxt_rec;
    logic [31:0]    a_word, s_word;

    always_comb begin
        accept = err_valid_i & (err_type_i == 2'b01 | err_type_i == 2'b10);
        full = count == CW'(FIFO_DEPTH);
        pop = state == S_ACCESS & i_pready;
        push = accept & (~full | pop);
        ovf_set = accept & full & ~pop;
        irq_set = irq_en_i & (ovf_set | (pop & cur_type == 2'b10));
        count_next = count + CW'(push) - CW'(pop);
        rd_next = rd_ptr + AW'(pop);
        rec_in = {err_type_i, err_addr_i, syndrome_i};
        // record to present next: bypass the incoming event when nothing else remains buffered
        nxt_rec = (count == CW'(pop)) ? rec_in : mem[rd_next];
        a_word = '0;
        a_word[ADDR_WIDTH-1:0] = nxt_rec[SW +: ADDR_WIDTH];
        a_word[16 +: SW] = nxt_rec[SW-1:0];
        s_word = '0;
        s_word[1:0] = cur_type;
        s_word[2] = ovf;
        s_word[16 +: CNT_WIDTH] = sec_cnt_o;
        s_word[24 +: CNT_WIDTH] = ded_cnt_o;
    end

    assign o_pwrite = o_psel;
    assign o_pstrb = {4{o_psel}};

    always_ff @(posedge ecc_err_logger_clk)
        if (push) mem[wr_ptr] <= rec_in;

    always_ff @(posedge ecc_err_logger_clk) begin
        if (ecc_err_logger_rst) begin
            state <= IDLE;
            o_psel <= 1'b0;
            o_penable <= 1'b0;
            o_paddr <= '0;
            o_pwdata <= '0;
            cur_type <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            ovf <= 1'b0;
            irq_o <= 1'b0;
            sec_cnt_o <= '0;
            ded_cnt_o <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_next;
            count <= count_next;
            if (accept & err_type_i == 2'b01 & ~&sec_cnt_o) sec_cnt_o <= sec_cnt_o + 1'b1;
            if (accept & err_type_i == 2'b10 & ~&ded_cnt_o) ded_cnt_o <= ded_cnt_o + 1'b1;
            ovf <= ovf_set | (ovf & ~irq_clr_i);
            irq_o <= irq_set | (irq_o & ~irq_clr_i);
            case (state)
                IDLE, S_ACCESS: begin
                    if (state == IDLE | i_pready) begin
                        if (count_next != '0) begin
                            state <= A_SETUP;
                            o_psel <= 1'b1;
                            o_penable <= 1'b0;
                            o_paddr <= ADDR_REG_OFS;
                            o_pwdata <= a_word;
                            cur_type <= nxt_rec[RW-1 -: 2];
                        end else begin
                            state <= IDLE;
                            o_psel <= 1'b0;
                            o_penable <= 1'b0;
                            o_paddr <= '0;
                            o_pwdata <= '0;
                        end
                    end
                end
                A_SETUP: begin
                    state <= A_ACCESS;
                    o_penable <= 1'b1;
                end
                S_SETUP: begin
                    state <= S_ACCESS;
                    o_penable <= 1'b1;
                end
                A_ACCESS: begin
                    if (i_pready) begin
                        state <= S_SETUP;
                        o_penable <= 1'b0;
                        o_paddr <= STAT_REG_OFS;
                        o_pwdata <= s_word;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
